bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the BCD-to-Excess-3 stage. It takes a binary value over a valid/ready handshake and produces packed BCD digits. Each nibble of its output feeds one BCD-to-Excess-3 converter instance.

Parameters:
BIN_W, 8, width of binary input in bits (>=1)
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^BIN_W-1 (elaboration-time check, $error if violated)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  bin_in is valid
in_ready  output  1  block can accept input; equals (state==IDLE)
bin_in  input  BIN_W  unsigned binary value
out_valid  output  1  bcd_out holds a completed conversion
out_ready  input  1  downstream accepts bcd_out
bcd_out  output  4*DIGITS  packed BCD; nibble [3:0] = units, [7:4] = tens, ...
busy  output  1  high in SHIFT state

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, bcd_out=0, busy=0, shift reg=0, bit counter=0. in_ready reads 1 while in reset (IDLE).
- FSM states: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch bin_in into the binary shift reg, clear the BCD accumulator, load counter=BIN_W, go to SHIFT.
  - in_valid=0: stay in IDLE.
- SHIFT: busy=1, in_ready=0. On each edge:
  - Add 3 to every accumulator digit >=5.
  - Shift {accumulator, binary reg} left by 1; the binary MSB enters accumulator bit 0.
  - Decrement the counter.
  - On the edge where the counter goes 1->0: register the final accumulator into bcd_out, set out_valid=1, go to DONE.
- Latency: the accept edge is edge 0. out_valid is first high after edge BIN_W, i.e. 8 cycles for the default.
- DONE:
  - out_valid=1; bcd_out held stable.
  - On an edge with out_ready=1: out_valid->0, go to IDLE. in_ready is high the following cycle; there is no same-cycle re-accept.
  - out_ready=0: hold indefinitely.
- bcd_out retains its last value after handshake until the next completion. It is only updated on entry to DONE.
- in_valid while not IDLE: ignored, no effect; the upstream must hold it until in_ready.
- out_ready outside DONE: ignored.
- Every bcd_out digit is always in 0..9. Digits above the needed count are 0.
- Reset mid-SHIFT or mid-DONE: immediate return to reset values; the conversion is discarded.
- Throughput: one conversion per BIN_W+2 cycles maximum with out_ready tied high.

Test Plan:
- Reset, then apply bin_in=0 with in_valid -> out_valid after 8 cycles, bcd_out=12'h000; out_ready=1 returns to IDLE, in_ready=1 next cycle.
- bin_in=255 -> bcd_out=12'h255 exactly 8 edges after accept. bin_in=99 -> 12'h099. bin_in=100 -> 12'h100. Sweep all 0..255 against a reference model; every nibble must be <=9.
- Backpressure: bin_in=57, out_ready low for 5 cycles after out_valid -> out_valid and bcd_out=12'h057 held stable. Release -> out_valid drops after one edge.
- Input while busy: change bin_in to 200 and pulse in_valid during SHIFT -> ignored; result remains that of the original value (e.g. 12'h013 for 13).
- Reset mid-operation: assert rst_n=0 asynchronously at cycle 4 of SHIFT for bin_in=180 -> out_valid=0, bcd_out=0, in_ready=1 immediately. Next conversion of 42 -> 12'h042.
- Back-to-back with in_valid and out_ready held high, inputs 9 then 10 -> two results 12'h009 and 12'h010, spaced 10 cycles apart.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy
);

  localparam int AW = 4 * DIGITS;
  localparam int SW = AW + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);

  function automatic logic digits_suffice();
    logic [127:0] pow10;
    pow10 = 128'd1;
    for (int i = 0; i < DIGITS; i++) pow10 = pow10 * 128'd10;
    return pow10 > ((128'd1 << BIN_W) - 128'd1);
  endfunction

  if (!digits_suffice()) begin : g_digits_check
    $error("bin2bcd_seq: DIGITS too small to hold the largest BIN_W-bit value");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  // sr = {BCD accumulator, binary operand}; shifting it as one word moves the binary MSB into the units digit
  logic [SW-1:0]   sr;
  logic [SW-1:0]   sr_adj;
  logic [SW-1:0]   sr_next;
  logic [CW-1:0]   cnt;

  always_comb begin
    sr_adj = sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr[BIN_W + 4*d +: 4] >= 4'd5)
        sr_adj[BIN_W + 4*d +: 4] = sr[BIN_W + 4*d +: 4] + 4'd3;
    end
    sr_next = sr_adj << 1;
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr    <= SW'(bin_in);
            cnt   <= CW'(BIN_W);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_out   <= sr_next[SW-1:BIN_W];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
